// File: rtl/window_spill_ctrl.sv
// Register-window controller: tracks the current window pointer and resident-window count,
// spilling the oldest window's two locals to a memory stack on overflow and refilling on underflow.
module window_spill_ctrl #(
  parameter int                NWIN     = 4,
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SP_BASE  = 'h00,
  parameter logic [ADDR_W-1:0] SP_LIMIT = 'hFE,
  localparam int               CW       = $clog2(NWIN),
  localparam int               OW       = CW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_req,
  input  logic              ret_req,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     cwp,
  output logic [CW-1:0]     rf_wnd,
  output logic [1:0]        rf_r,
  output logic              rf_wen,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPILL_RD = 3'd1,
    SPILL_WR = 3'd2,
    FILL_RD  = 3'd3,
    FILL_WR  = 3'd4,
    FINISH   = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cwp_reg, cwp_next;
  logic [OW-1:0]       occ_reg, occ_next;
  logic [ADDR_W-1:0]   sp_reg, sp_next;
  logic [CW-1:0]       victim_reg, victim_next;
  logic                k_reg, k_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0]   rf_wdata_reg, rf_wdata_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cwp_reg       <= '0;
      occ_reg       <= OW'(1);
      sp_reg        <= SP_BASE;
      victim_reg    <= '0;
      k_reg         <= 1'b0;
      mem_wdata_reg <= '0;
      rf_wdata_reg  <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cwp_reg       <= cwp_next;
      occ_reg       <= occ_next;
      sp_reg        <= sp_next;
      victim_reg    <= victim_next;
      k_reg         <= k_next;
      mem_wdata_reg <= mem_wdata_next;
      rf_wdata_reg  <= rf_wdata_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cwp_next       = cwp_reg;
    occ_next       = occ_reg;
    sp_next        = sp_reg;
    victim_next    = victim_reg;
    k_next         = k_reg;
    mem_wdata_next = mem_wdata_reg;
    rf_wdata_next  = rf_wdata_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    req_ready      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    rf_wen         = 1'b0;
    rf_wnd         = cwp_reg;
    rf_r           = 2'd0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (call_req && ret_req) begin
          err_next = 1'b1;
        end else if (call_req) begin
          if (occ_reg < OW'(NWIN - 1)) begin
            cwp_next   = cwp_reg + CW'(1);
            occ_next   = occ_reg + OW'(1);
            state_next = FINISH;
          end else if (sp_reg >= SP_LIMIT) begin
            err_next = 1'b1;
          end else begin
            // Oldest resident window sits NWIN-2 slots behind the current one.
            victim_next = cwp_reg - CW'(NWIN - 2);
            k_next      = 1'b0;
            state_next  = SPILL_RD;
          end
        end else if (ret_req) begin
          if (occ_reg > OW'(1)) begin
            cwp_next   = cwp_reg - CW'(1);
            occ_next   = occ_reg - OW'(1);
            state_next = FINISH;
          end else if (sp_reg == SP_BASE) begin
            err_next = 1'b1;
          end else begin
            victim_next = cwp_reg - CW'(1);
            k_next      = 1'b0;
            state_next  = FILL_RD;
          end
        end
      end

      SPILL_RD: begin
        rf_wnd         = victim_reg;
        rf_r           = {1'b0, k_reg};
        mem_wdata_next = rf_rdata;
        state_next     = SPILL_WR;
      end

      SPILL_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = sp_reg + ADDR_W'(k_reg);
        if (mem_ack) begin
          if (!k_reg) begin
            k_next     = 1'b1;
            state_next = SPILL_RD;
          end else begin
            sp_next    = sp_reg + ADDR_W'(2);
            cwp_next   = cwp_reg + CW'(1);
            state_next = FINISH;
          end
        end
      end

      FILL_RD: begin
        mem_req  = 1'b1;
        mem_addr = sp_reg - ADDR_W'(2) + ADDR_W'(k_reg);
        if (mem_ack) begin
          rf_wdata_next = mem_rdata;
          state_next    = FILL_WR;
        end
      end

      FILL_WR: begin
        rf_wen = 1'b1;
        rf_wnd = victim_reg;
        rf_r   = {1'b0, k_reg};
        if (!k_reg) begin
          k_next     = 1'b1;
          state_next = FILL_RD;
        end else begin
          sp_next    = sp_reg - ADDR_W'(2);
          cwp_next   = cwp_reg - CW'(1);
          state_next = FINISH;
        end
      end

      FINISH: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign cwp       = cwp_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rf_wdata  = rf_wdata_reg;

  // The memory handshake must hold its request and payload until acknowledged.
  a_mem_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && err));

endmodule

// File: tb/tb_window_spill_ctrl.sv
// Randomized scoreboard bench for window_spill_ctrl: a window-stack reference model predicts
// responses, spill writes and fill writes; a negedge monitor pops and compares them.
module tb_window_spill_ctrl;
  localparam int         NWIN   = 4;
  localparam int         DATA_W = 16;
  localparam int         ADDR_W = 8;
  localparam logic [7:0] SP_LIM = 8'h08;

  logic              clk, rst_n, call_req, ret_req;
  logic              req_ready, done, err, rf_wen, mem_req, mem_we, mem_ack;
  logic [1:0]        cwp, rf_wnd, rf_r;
  logic [DATA_W-1:0] rf_wdata, rf_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  window_spill_ctrl #(
    .NWIN(NWIN), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_BASE(8'h00), .SP_LIMIT(SP_LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .ret_req(ret_req),
    .req_ready(req_ready), .done(done), .err(err), .cwp(cwp),
    .rf_wnd(rf_wnd), .rf_r(rf_r), .rf_wen(rf_wen), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_err; logic [1:0] cwp; int lat; int issue; } resp_t;
  typedef struct { bit we; logic [7:0] addr; logic [15:0] data; } mem_t;
  typedef struct { logic [1:0] wnd; logic [1:0] r; logic [15:0] data; } rf_t;

  resp_t exp_resp[$];
  mem_t  exp_mem[$];
  rf_t   exp_rf[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment: register file and spill memory.
  logic [15:0] rf_arr [NWIN][4];
  logic [15:0] mem_arr [256];
  assign rf_rdata = rf_arr[rf_wnd][rf_r];

  always @(posedge clk) begin
    if (rf_wen)
      rf_arr[rf_wnd][rf_r] = rf_wdata;
    else if (req_ready && !call_req && !ret_req)
      for (int w = 0; w < NWIN; w++)
        for (int r = 0; r < 4; r++)
          rf_arr[w][r] = 16'($urandom);
    if (mem_req && mem_we && mem_ack)
      mem_arr[mem_addr] = mem_wdata;
  end

  bit hold_ack = 1'b0;
  initial begin
    int wait_cnt;
    int delay;
    wait_cnt  = 0;
    delay     = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mem_req) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) delay = $urandom_range(0, 3);
        mem_ack   = !hold_ack && (wait_cnt >= delay);
        mem_rdata = mem_ack ? mem_arr[mem_addr] : 16'($urandom);
        wait_cnt++;
      end
    end
  end

  // Monitor
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [15:0] prev_wd = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (done || err) begin
        if (exp_resp.size() == 0) begin
          check("resp_unexpected", {done, err}, 2'b00);
        end else begin
          resp_t e;
          e = exp_resp.pop_front();
          check("resp_done", done, !e.is_err);
          check("resp_err", err, e.is_err);
          check("resp_cwp", cwp, e.cwp);
          if (e.lat >= 0) check("resp_latency", cyc - e.issue, e.lat);
        end
      end
      if (prev_req && !prev_ack)
        check("mem_hold", {mem_req, mem_we, mem_addr, mem_wdata},
              {1'b1, prev_we, prev_addr, prev_wd});
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          check("mem_unexpected", {mem_we, mem_addr}, 9'h1ff);
        end else begin
          mem_t m;
          m = exp_mem.pop_front();
          check("mem_we", mem_we, m.we);
          check("mem_addr", mem_addr, m.addr);
          if (m.we) check("mem_wdata", mem_wdata, m.data);
        end
      end
      if (rf_wen) begin
        if (exp_rf.size() == 0) begin
          check("rf_unexpected", rf_wen, 1'b0);
        end else begin
          rf_t f;
          f = exp_rf.pop_front();
          check("rf_wnd", rf_wnd, f.wnd);
          check("rf_r", rf_r, f.r);
          check("rf_wdata", rf_wdata, f.data);
        end
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_we   = mem_we;
      prev_addr = mem_addr;
      prev_wd   = mem_wdata;
    end
  end

  // Reference model: a window stack with NWIN-1 resident slots and a saved-pair stack.
  logic [1:0]  cwp_m;
  int          occ_m;
  logic [7:0]  sp_m;
  logic [31:0] saved[$];

  task automatic model_reset();
    cwp_m = 2'd0;
    occ_m = 1;
    sp_m  = 8'h00;
    saved.delete();
    exp_resp.delete();
    exp_mem.delete();
    exp_rf.delete();
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    call_req = 1'b0;
    ret_req  = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic push_resp(input bit is_err, input int lat);
    resp_t r;
    r.is_err = is_err;
    r.cwp    = cwp_m;
    r.lat    = lat;
    r.issue  = cyc;
    exp_resp.push_back(r);
  endtask

  task automatic do_req(input bit c, input bit r);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    if (c && r) begin
      push_resp(1'b1, 1);
    end else if (c) begin
      if (occ_m < NWIN - 1) begin
        cwp_m++;
        occ_m++;
        push_resp(1'b0, 2);
      end else if (sp_m >= SP_LIM) begin
        push_resp(1'b1, 1);
      end else begin
        logic [1:0]  oldest;
        logic [15:0] d0, d1;
        oldest = cwp_m - 2'(occ_m - 1);
        d0 = rf_arr[oldest][0];
        d1 = rf_arr[oldest][1];
        exp_mem.push_back('{1'b1, sp_m, d0});
        exp_mem.push_back('{1'b1, sp_m + 8'd1, d1});
        saved.push_back({d1, d0});
        sp_m += 8'd2;
        cwp_m++;
        push_resp(1'b0, -1);
      end
    end else if (r) begin
      if (occ_m > 1) begin
        cwp_m--;
        occ_m--;
        push_resp(1'b0, 2);
      end else if (sp_m == 8'h00) begin
        push_resp(1'b1, 1);
      end else begin
        logic [31:0] pair;
        logic [1:0]  tgt;
        tgt  = cwp_m - 2'd1;
        pair = saved.pop_back();
        exp_mem.push_back('{1'b0, sp_m - 8'd2, 16'h0});
        exp_mem.push_back('{1'b0, sp_m - 8'd1, 16'h0});
        exp_rf.push_back('{tgt, 2'd0, pair[15:0]});
        exp_rf.push_back('{tgt, 2'd1, pair[31:16]});
        sp_m -= 8'd2;
        cwp_m = tgt;
        push_resp(1'b0, -1);
      end
    end
    call_req = c;
    ret_req  = r;
    n = 0;
    do begin
      @(negedge clk);
      if (!req_ready) begin
        call_req = 1'($urandom);
        ret_req  = 1'($urandom);
      end else begin
        call_req = 1'b0;
        ret_req  = 1'b0;
      end
      n++;
    end while (!(req_ready && exp_resp.size() == 0 && exp_mem.size() == 0 && exp_rf.size() == 0)
               && n < 300);
    call_req = 1'b0;
    ret_req  = 1'b0;
    if (n >= 300) begin
      check("req_timeout", 1'b1, 1'b0);
      exp_resp.delete();
      exp_mem.delete();
      exp_rf.delete();
    end
    $display("[TB] req call=%0d ret=%0d -> cwp=%0d occ=%0d sp=%0h", c, r, cwp_m, occ_m, sp_m);
  endtask

  initial begin
    rst_n    = 1'b0;
    call_req = 1'b0;
    ret_req  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cwp", cwp, 2'd0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_rf_wdata", rf_wdata, 16'h0);
    check("rst_rf_r", rf_r, 2'd0);
    check("rst_rf_wnd", rf_wnd, 2'd0);
    apply_reset();

    // Directed: underflow, conflicting request, plain calls, spill, returns with a fill.
    do_req(1'b0, 1'b1);
    do_req(1'b1, 1'b1);
    do_req(1'b1, 1'b0);
    do_req(1'b1, 1'b0);
    do_req(1'b1, 1'b0);
    do_req(1'b0, 1'b1);
    do_req(1'b0, 1'b1);
    do_req(1'b0, 1'b1);
    check("dir_cwp_after_fill", cwp, 2'd0);

    // Random walk biased upward first (reaching the spill limit) then downward.
    for (int i = 0; i < 400; i++) begin
      int  pc;
      bit  c, r;
      pc = (i < 200) ? 65 : 35;
      if ($urandom_range(0, 99) < 5) begin
        c = 1'b1;
        r = 1'b1;
      end else begin
        c = ($urandom_range(0, 99) < pc);
        r = !c;
      end
      do_req(c, r);
    end

    // Reset in the middle of a stalled spill write.
    apply_reset();
    do_req(1'b1, 1'b0);
    do_req(1'b1, 1'b0);
    hold_ack = 1'b1;
    call_req = 1'b1;
    @(negedge clk);
    call_req = 1'b0;
    begin
      int n;
      n = 0;
      while (!mem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("stall_mem_req", mem_req, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 1'b0);
    check("async_rst_cwp", cwp, 2'd0);
    check("async_rst_req_ready", req_ready, 1'b1);
    hold_ack = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cwp", cwp, 2'd0);
    check("post_rst_ready", req_ready, 1'b1);
    do_req(1'b1, 1'b0);
    do_req(1'b0, 1'b1);
    do_req(1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("left_resp", exp_resp.size(), 0);
    check("left_mem", exp_mem.size(), 0);
    check("left_rf", exp_rf.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
